// File: rtl/seq_serializer.sv
// LSB-first serializer: loads a word on start, shifts out up to WIDTH bits with
// receiver back-pressure, then pulses done for one cycle before returning to idle.
module seq_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [5:0]       nbits,
  input  logic             hold,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [5:0] WIDTH_L  = 6'(WIDTH);

  // Bit 0 lives in dout_r, so the shift register only keeps the remaining upper bits.
  logic [1:0]       state_r, state_s;
  logic [WIDTH-2:0] shift_r, shift_s;
  logic [5:0]       cnt_r, cnt_s, len_s;
  logic             dout_r, dout_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Effective frame length: zero or oversize requests fall back to a full word.
  always_comb begin
    if ((nbits == 6'd0) || (nbits > WIDTH_L)) begin
      len_s = WIDTH_L;
    end else begin
      len_s = nbits;
    end
  end

  // Next-state and next-output computation for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    dout_s  = dout_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SHIFT;
          shift_s = data[WIDTH-1:1];
          cnt_s   = len_s;
          dout_s  = data[0];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          dout_s  = 1'b0;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (hold) begin
          state_s = ST_SHIFT;
        end else if (cnt_r == 6'd1) begin
          state_s = ST_DONE;
          shift_s = {(WIDTH-1){1'b0}};
          cnt_s   = 6'd0;
          dout_s  = 1'b0;
          valid_s = 1'b0;
          done_s  = 1'b1;
        end else begin
          shift_s = shift_r >> 1'b1;
          cnt_s   = cnt_r - 6'd1;
          dout_s  = shift_r[0];
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        dout_s  = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        shift_s = {(WIDTH-1){1'b0}};
        cnt_s   = 6'd0;
        dout_s  = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      shift_r <= {(WIDTH-1){1'b0}};
      cnt_r   <= 6'd0;
      dout_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      dout_r  <= dout_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter: WIDTH, default 32, maximum number of bits per frame (supported range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to load and send a frame; sampled only in IDLE.
REQ-005 data  input  WIDTH  frame word; captured on accepted start.
REQ-006 nbits  input  6  bits to send; captured with data; 0 or >WIDTH means WIDTH.
REQ-007 hold  input  1  receiver back-pressure; 1 = current bit not consumed this cycle.
REQ-008 dout  output  1  serial data bit, registered.
REQ-009 dout_valid  output  1  dout carries a valid frame bit, registered.
REQ-010 busy  output  1  high in SHIFT and DONE states.
REQ-011 done  output  1  one-cycle pulse after the last bit is consumed.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE; encoding is free.
REQ-013 IDLE: start=1 at edge N SHALL capture data into a shift register, capture effective length into a bit counter, and enter SHIFT.
REQ-014 Bits SHALL be sent LSB first: data[0] first, then data[1], and so on.
REQ-015 In the cycle after edge N, dout SHALL equal data[0] and dout_valid SHALL be 1 (one-cycle load latency).
REQ-016 A bit SHALL count as transferred on an edge where dout_valid=1 and hold=0; only then does the register shift right and the counter decrement.
REQ-017 While hold=1 in SHIFT, dout, dout_valid, the shift register and the counter SHALL hold their values.
REQ-018 On the edge that transfers the last bit (counter=1, hold=0), the FSM SHALL enter DONE; dout_valid=0, dout=0 and done=1 in that DONE cycle.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally; done SHALL be 0 in all other states.
REQ-020 start SHALL be ignored in SHIFT and DONE, with no effect on the frame in flight and no queuing; the earliest new frame is accepted on the first IDLE edge.
REQ-021 data and nbits changes after acceptance SHALL NOT affect the frame in flight.
REQ-022 Effective length: nbits=0 -> WIDTH; nbits>WIDTH -> WIDTH; otherwise nbits. The counter SHALL be wide enough for WIDTH with no wrap.
REQ-023 With hold=0 throughout, frame duration SHALL be: start edge, L valid cycles, one DONE cycle, for L+1 cycles of busy.
REQ-024 In IDLE, dout=0, dout_valid=0, busy=0 and done=0.
REQ-025 If hold=1 and start=1 in IDLE, start SHALL still be accepted; hold affects only SHIFT.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, clear the shift register and counter, and drive dout=0, dout_valid=0, busy=0 and done=0 in the following cycle; rst has priority over start and hold.
REQ-027 Reset in mid-frame SHALL abort the frame with no done pulse; remaining bits are discarded.
REQ-028 After rst falls, start SHALL be accepted on the first edge with rst=0.

Verification
REQ-029 data=32'h6AA36155, nbits=0, hold=0 -> 32 valid cycles with dout sequence 1,0,1,0,1,0,1,0 (0x55 LSB first) ... last bit 0; done pulses in cycle 33 after the start edge; busy high for 33 cycles.
REQ-030 data=32'h0000000B, nbits=4, hold=0 -> dout 1,1,0,1 across 4 valid cycles, then done; nbits=40 -> behaves as 32.
REQ-031 Same as REQ-029 with hold=1 for 3 cycles during bit 5 -> bit 5 held for 4 cycles, sequence unchanged, done delayed by exactly 3 cycles.
REQ-032 start pulsed during SHIFT with different data -> ignored; the original frame completes intact; a start in the first IDLE cycle after DONE launches the new frame.
REQ-033 rst asserted at bit 10 of a 32-bit frame -> next cycle all outputs 0, no done pulse; start after release sends a full new frame from bit 0.
